// File: rtl/ram_pkg.sv
// Shared definitions for the single-port RAM write generator and read checker.
// Holds the default RAM geometry, the checker FSM state type and the one
// pattern definition both sides agree on: expected(a) = seed + a, truncated
// by the caller to its data width.
package ram_pkg;

  localparam int unsigned RamAddrW = 5;
  localparam int unsigned RamDataW = 8;
  localparam int unsigned RamDepth = 32;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain,
    StDone
  } ram_state_e;

  // Full 32-bit sum; callers keep the low DATA_W bits, which gives the wrap.
  function automatic logic [31:0] expected(input logic [31:0] seed, input logic [31:0] addr);
    return seed + addr;
  endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// READ_LAT-deep {valid, addr} delay line that tracks reads in flight through
// the RAM so each returned word can be matched to the address that fetched it.
// Ports:
//   clka, rst      - RAM clock, asynchronous active-low reset
//   push_i         - a read is issued this cycle
//   push_addr_i    - address of that read
//   out_valid_o    - output stage holds a read whose data is on douta now
//   out_addr_o     - address of that read
//   pending_o      - some read is still in a stage before the output stage
module ram_rd_pipe #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clka,
  input  logic              rst,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  output logic              out_valid_o,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic              pending_o
);

  logic [READ_LAT-1:0] valid_q, valid_d;
  logic [ADDR_W-1:0]   addr_q [READ_LAT];
  logic [ADDR_W-1:0]   addr_d [READ_LAT];

  always_comb begin
    valid_d[0] = push_i;
    addr_d[0]  = push_addr_i;
    for (int i = 1; i < int'(READ_LAT); i++) begin
      valid_d[i] = valid_q[i-1];
      addr_d[i]  = addr_q[i-1];
    end
  end

  // Only the stages ahead of the output count; the output stage is being
  // consumed on the same edge this is looked at.
  always_comb begin
    pending_o = 1'b0;
    for (int i = 0; i + 1 < int'(READ_LAT); i++) begin
      pending_o = pending_o | valid_q[i];
    end
  end

  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < int'(READ_LAT); i++) begin
        addr_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < int'(READ_LAT); i++) begin
        addr_q[i] <= addr_d[i];
      end
    end
  end

  assign out_valid_o = valid_q[READ_LAT-1];
  assign out_addr_o  = addr_q[READ_LAT-1];

endmodule

// File: rtl/ram_rd_chk.sv
// Read-side checker for the single-port block RAM. A start pulse launches one
// read sweep over addresses 0..DEPTH-1 (wea held low); every returned word is
// compared with the incrementing pattern from ram_pkg::expected.
// Ports:
//   clka, rst       - RAM clock, asynchronous active-low reset
//   start           - one-cycle sweep request (ignored while busy)
//   douta           - RAM read data
//   ena, wea, addra - RAM control; wea is always 0
//   busy            - sweep in progress
//   done            - one-cycle pulse when the last word has been checked
//   pass            - last sweep had no mismatches, held until next start
//   err_cnt         - saturating mismatch count of the last/current sweep
//   first_err_addr  - address of the first mismatch of the sweep
//   first_err_data  - douta value seen at that first mismatch
// READ_LAT must lie in 1..4.
module ram_rd_chk
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_W   = RamAddrW,
  parameter int unsigned DATA_W   = RamDataW,
  parameter int unsigned DEPTH    = RamDepth,
  parameter int unsigned READ_LAT = 1,
  parameter int unsigned SEED     = 0
) (
  input  logic              clka,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] douta,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   ErrMax   = '1;

  ram_state_e        state_q, state_d;
  logic              ena_q, ena_d;
  logic [ADDR_W-1:0] addra_q, addra_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [ADDR_W:0]   err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0] first_err_addr_q, first_err_addr_d;
  logic [DATA_W-1:0] first_err_data_q, first_err_data_d;
  logic              first_seen_q, first_seen_d;

  logic              pipe_valid;
  logic [ADDR_W-1:0] pipe_addr;
  logic              pipe_pending;
  logic [DATA_W-1:0] exp_data;
  logic              mismatch;

  // ena is high exactly in READ, so it doubles as the push strobe.
  ram_rd_pipe #(
    .ADDR_W  (ADDR_W),
    .READ_LAT(READ_LAT)
  ) u_pipe (
    .clka       (clka),
    .rst        (rst),
    .push_i     (ena_q),
    .push_addr_i(addra_q),
    .out_valid_o(pipe_valid),
    .out_addr_o (pipe_addr),
    .pending_o  (pipe_pending)
  );

  assign exp_data = DATA_W'(expected(SEED, 32'(pipe_addr)));
  assign mismatch = pipe_valid && (douta != exp_data);

  always_comb begin
    state_d          = state_q;
    ena_d            = ena_q;
    addra_d          = addra_q;
    busy_d           = busy_q;
    done_d           = 1'b0;
    pass_d           = pass_q;
    err_cnt_d        = err_cnt_q;
    first_err_addr_d = first_err_addr_q;
    first_err_data_d = first_err_data_q;
    first_seen_d     = first_seen_q;

    if (mismatch) begin
      if (err_cnt_q != ErrMax) begin
        err_cnt_d = err_cnt_q + (ADDR_W+1)'(1);
      end
      if (!first_seen_q) begin
        first_seen_d     = 1'b1;
        first_err_addr_d = pipe_addr;
        first_err_data_d = douta;
      end
    end

    case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start) begin
          state_d          = StRead;
          ena_d            = 1'b1;
          addra_d          = '0;
          busy_d           = 1'b1;
          pass_d           = 1'b0;
          err_cnt_d        = '0;
          first_err_addr_d = '0;
          first_err_data_d = '0;
          first_seen_d     = 1'b0;
        end
      end
      StRead: begin
        if (addra_q == LastAddr) begin
          state_d = StDrain;
          ena_d   = 1'b0;
          addra_d = '0;
        end else begin
          addra_d = addra_q + ADDR_W'(1);
        end
      end
      StDrain: begin
        // The last read is in the output stage and checked on this edge.
        if (!pipe_pending) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_cnt_d == '0);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      state_q          <= StIdle;
      ena_q            <= 1'b0;
      addra_q          <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      err_cnt_q        <= '0;
      first_err_addr_q <= '0;
      first_err_data_q <= '0;
      first_seen_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      ena_q            <= ena_d;
      addra_q          <= addra_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      pass_q           <= pass_d;
      err_cnt_q        <= err_cnt_d;
      first_err_addr_q <= first_err_addr_d;
      first_err_data_q <= first_err_data_d;
      first_seen_q     <= first_seen_d;
    end
  end

  assign ena            = ena_q;
  assign wea            = 1'b0;
  assign addra          = addra_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_err_addr_q;
  assign first_err_data = first_err_data_q;

endmodule

// File: tb/tb_ram_rd_chk.sv
// Bench for ram_rd_chk: one checker with a plain RAM model (READ_LAT=1, SEED=0)
// and one with an output-registered RAM model (READ_LAT=2, SEED=250).
module tb_ram_rd_chk;

  localparam int AW    = 5;
  localparam int DW    = 8;
  localparam int DEPTH = 32;

  typedef struct packed {
    logic          ena;
    logic          wea;
    logic          busy;
    logic          done;
    logic          pass;
    logic [AW-1:0] addra;
    logic [AW-1:0] fea;
    logic [AW:0]   err;
    logic [DW-1:0] fed;
  } obs_t;

  typedef struct {
    string name;
    int    which;
    int    bad_a0;
    int    bad_d0;
    int    bad_a1;
    int    bad_d1;
    bit    all_bad;
    int    exp_err;
    bit    exp_pass;
    int    exp_fa;
    int    exp_fd;
  } vec_t;

  logic clka = 1'b0;
  always #5 clka = ~clka;

  logic          rst;
  logic          start1, start2;
  logic [DW-1:0] douta1, douta2, q2;
  logic          ena1, wea1, busy1, done1, pass1;
  logic          ena2, wea2, busy2, done2, pass2;
  logic [AW-1:0] addra1, fea1, addra2, fea2;
  logic [AW:0]   err1, err2;
  logic [DW-1:0] fed1, fed2;
  logic [DW-1:0] mem1 [DEPTH];
  logic [DW-1:0] mem2 [DEPTH];
  obs_t          o1, o2;

  ram_rd_chk #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .READ_LAT(1), .SEED(0)
  ) dut1 (
    .clka(clka), .rst(rst), .start(start1), .douta(douta1),
    .ena(ena1), .wea(wea1), .addra(addra1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .first_err_addr(fea1), .first_err_data(fed1)
  );

  ram_rd_chk #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .READ_LAT(2), .SEED(250)
  ) dut2 (
    .clka(clka), .rst(rst), .start(start2), .douta(douta2),
    .ena(ena2), .wea(wea2), .addra(addra2), .busy(busy2), .done(done2), .pass(pass2),
    .err_cnt(err2), .first_err_addr(fea2), .first_err_data(fed2)
  );

  // RAM models: plain synchronous read, and read plus output register.
  always @(posedge clka) if (ena1) douta1 <= mem1[addra1];
  always @(posedge clka) begin
    if (ena2) q2 <= mem2[addra2];
    douta2 <= q2;
  end

  assign o1 = {ena1, wea1, busy1, done1, pass1, addra1, fea1, err1, fed1};
  assign o2 = {ena2, wea2, busy2, done2, pass2, addra2, fea2, err2, fed2};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic obs_t obs(input int w);
    return (w == 1) ? o1 : o2;
  endfunction

  task automatic set_start(input int w, input logic v);
    if (w == 1) start1 = v;
    else start2 = v;
  endtask

  task automatic load_mem(input int w, input bit all_bad, input int a0, input int d0,
                          input int a1, input int d1);
    int seed;
    seed = (w == 1) ? 0 : 250;
    for (int a = 0; a < DEPTH; a++) begin
      logic [DW-1:0] v;
      v = DW'(seed + a);
      if (all_bad) v = ~v;
      if (w == 1) mem1[a] = v;
      else mem2[a] = v;
    end
    if (a0 >= 0) begin
      if (w == 1) mem1[a0] = DW'(d0);
      else mem2[a0] = DW'(d0);
    end
    if (a1 >= 0) begin
      if (w == 1) mem1[a1] = DW'(d1);
      else mem2[a1] = DW'(d1);
    end
  endtask

  // Pulses start (sampled at edge t0) and watches every cycle after it.
  // lat = edges after t0 until done is seen; seq_ok covers ena/addra/busy.
  task automatic run_sweep(input int w, input int repulse_at, input int extra,
                           output int lat, output bit seq_ok, output int n_done);
    obs_t o;
    int   k;
    lat    = -1;
    seq_ok = 1'b1;
    n_done = 0;
    k      = 0;
    @(negedge clka);
    set_start(w, 1'b1);
    @(posedge clka);
    #1;
    set_start(w, 1'b0);
    while (1'b1) begin
      o = obs(w);
      if (o.done) begin
        n_done++;
        if (lat < 0) lat = k;
        if (o.busy !== 1'b0) seq_ok = 1'b0;
      end else if (lat < 0) begin
        if (o.busy !== 1'b1) seq_ok = 1'b0;
        if (k < DEPTH) begin
          if (o.ena !== 1'b1 || o.addra !== AW'(k)) seq_ok = 1'b0;
        end else if (o.ena !== 1'b0 || o.addra !== '0) begin
          seq_ok = 1'b0;
        end
      end else if (o.busy !== 1'b0) begin
        seq_ok = 1'b0;
      end
      if (lat >= 0 && k >= lat + extra) break;
      if (k >= 80) break;
      set_start(w, (repulse_at >= 0 && lat < 0 && o.busy && o.addra == AW'(repulse_at)));
      @(posedge clka);
      #1;
      k++;
    end
    if (extra > 0) set_start(w, 1'b0);
  endtask

  vec_t vecs [6];
  int   lat, nd, k;
  bit   ok;
  obs_t e;

  initial begin
    vecs[0] = '{"l1_two_errs", 1, 5, 8'hAA, 17, 8'h00, 1'b0, 2, 1'b0, 5, 8'hAA};
    vecs[1] = '{"l1_clean",    1, -1, 0, -1, 0, 1'b0, 0, 1'b1, 0, 0};
    vecs[2] = '{"l2_clean",    2, -1, 0, -1, 0, 1'b0, 0, 1'b1, 0, 0};
    vecs[3] = '{"l2_two_errs", 2, 6, 8'h01, 31, 8'h20, 1'b0, 2, 1'b0, 6, 8'h01};
    vecs[4] = '{"l1_all_bad",  1, -1, 0, -1, 0, 1'b1, 32, 1'b0, 0, 8'hFF};
    vecs[5] = '{"l1_clean2",   1, -1, 0, -1, 0, 1'b0, 0, 1'b1, 0, 0};

    rst    = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    repeat (3) @(posedge clka);
    #1;
    check("reset_dut1", 32'(o1), 32'd0);
    check("reset_dut2", 32'(o2), 32'd0);
    @(negedge clka);
    rst = 1'b1;

    foreach (vecs[i]) begin
      load_mem(vecs[i].which, vecs[i].all_bad, vecs[i].bad_a0, vecs[i].bad_d0,
               vecs[i].bad_a1, vecs[i].bad_d1);
      run_sweep(vecs[i].which, -1, 3, lat, ok, nd);
      e = obs(vecs[i].which);
      check({vecs[i].name, "_latency"}, 32'(lat), 32'(DEPTH + vecs[i].which));
      check({vecs[i].name, "_addr_seq"}, 32'(ok), 32'd1);
      check({vecs[i].name, "_done_pulses"}, 32'(nd), 32'd1);
      check({vecs[i].name, "_pass"}, 32'(e.pass), 32'(vecs[i].exp_pass));
      check({vecs[i].name, "_err_cnt"}, 32'(e.err), 32'(vecs[i].exp_err));
      check({vecs[i].name, "_first_addr"}, 32'(e.fea), 32'(vecs[i].exp_fa));
      check({vecs[i].name, "_first_data"}, 32'(e.fed), 32'(vecs[i].exp_fd));
    end

    // start re-pulsed mid-sweep must be ignored.
    load_mem(1, 1'b0, -1, 0, -1, 0);
    run_sweep(1, 12, 10, lat, ok, nd);
    check("repulse_latency", 32'(lat), 32'd33);
    check("repulse_addr_seq", 32'(ok), 32'd1);
    check("repulse_done_pulses", 32'(nd), 32'd1);
    check("repulse_pass", 32'(pass1), 32'd1);

    // start in the DONE cycle launches a fresh sweep immediately.
    load_mem(1, 1'b0, 5, 8'hAA, -1, 0);
    run_sweep(1, -1, 0, lat, ok, nd);
    check("b2b_first_latency", 32'(lat), 32'd33);
    check("b2b_first_err_cnt", 32'(err1), 32'd1);
    start1 = 1'b1;
    @(posedge clka);
    #1;
    start1 = 1'b0;
    e      = '0;
    e.ena  = 1'b1;
    e.busy = 1'b1;
    check("b2b_restart_state", 32'(o1), 32'(e));
    k = 0;
    while (!done1 && k < 60) begin
      @(posedge clka);
      #1;
      k++;
    end
    check("b2b_second_latency", 32'(k), 32'd33);
    check("b2b_second_err_cnt", 32'(err1), 32'd1);
    check("b2b_second_first_addr", 32'(fea1), 32'd5);

    // Asynchronous reset in the middle of a sweep.
    load_mem(1, 1'b0, -1, 0, -1, 0);
    @(negedge clka);
    start1 = 1'b1;
    @(posedge clka);
    #1;
    start1 = 1'b0;
    k = 0;
    while (addra1 != AW'(10) && k < 40) begin
      @(posedge clka);
      #1;
      k++;
    end
    check("rst_mid_reach_addr10", 32'(k), 32'd10);
    rst = 1'b0;
    #1;
    check("rst_mid_outputs", 32'(o1), 32'd0);
    repeat (2) @(posedge clka);
    @(negedge clka);
    rst = 1'b1;
    run_sweep(1, -1, 3, lat, ok, nd);
    check("rst_after_latency", 32'(lat), 32'd33);
    check("rst_after_addr_seq", 32'(ok), 32'd1);
    check("rst_after_pass", 32'(pass1), 32'd1);
    check("rst_after_err_cnt", 32'(err1), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_rd_chk.md
Name: ram_rd_chk

Overview:
- Read-side counterpart of the single-port RAM write pattern generator.
- On a start pulse it drives a full read sweep of the single-port block RAM, addresses 0..DEPTH-1, with wea held low.
- It compares each returned douta against the expected incrementing pattern and reports pass/fail, an error count, and the first failing address and data.
- It sits beside the RAM IP and shares the RAM's clka/rst domain.

Parameters:
- ADDR_W, 5, RAM address width.
- DATA_W, 8, RAM data width.
- DEPTH, 32, number of words checked (≤ 2^ADDR_W).
- READ_LAT, 1, RAM read latency in cycles: 1 = no output register, 2 = output register; legal range 1..4.
- SEED, 0, expected data at address 0; expected(a) = (SEED + a) mod 2^DATA_W.

Ports:
- clka, input, 1, RAM clock; all logic is posedge.
- rst, input, 1, asynchronous active-low reset.
- start, input, 1, single-cycle request to begin a sweep.
- douta, input, DATA_W, RAM read data.
- ena, output, 1, RAM enable.
- wea, output, 1, RAM write enable; constant 0.
- addra, output, ADDR_W, RAM address.
- busy, output, 1, sweep in progress.
- done, output, 1, one-cycle pulse at end of sweep.
- pass, output, 1, last sweep had zero mismatches; held until the next start.
- err_cnt, output, ADDR_W+1, mismatch count of the last or current sweep.
- first_err_addr, output, ADDR_W, address of the first mismatch.
- first_err_data, output, DATA_W, douta value at the first mismatch.

Behaviour:
- Reset: rst asynchronous, active-low; clock clka.
  - While rst=0: state IDLE; ena, addra, busy, done, pass, err_cnt, first_err_addr, first_err_data all 0; read pipeline cleared.
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE: on start=1, go to READ. Clear err_cnt, pass, first_err_*, and the first-error flag. Set addra=0, ena=1, busy=1.
  - READ: ena=1 every cycle and addra increments by 1 per cycle. When addra = DEPTH-1 is presented, the next state is DRAIN with ena=0 and addra returned to 0.
  - DRAIN: ena=0. Stay until the valid pipeline is empty (READ_LAT cycles after the last address), then go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0, pass=(err_cnt==0). Next state is IDLE.
  - start in DONE is honoured as in IDLE (back-to-back sweep).
- start is ignored while busy=1; the sweep is not restarted.
- Read pipeline: a READ_LAT-deep shift register of {valid, addr}. Entry pushed on every READ cycle.
  - When the output stage is valid, douta is compared with expected(addr) on that edge.
- Mismatch handling: err_cnt increments, saturating at 2^(ADDR_W+1)-1. On the first mismatch of a sweep, first_err_addr and first_err_data are captured; they are not overwritten later.
- Timing: with start sampled at edge t0, address a is driven during cycle t0+1+a. Its data is compared at edge t0+1+a+READ_LAT. done is high in cycle t0+DEPTH+READ_LAT+1.
- Width rules:
  - Expected value is computed in DATA_W bits and wraps modulo 2^DATA_W, e.g. SEED=250 gives expected(10)=4.
  - addra wraps only at DEPTH-1, never beyond.
- Reset mid-sweep: all state is dropped immediately; the next start performs a clean full sweep.
- wea is tied 0 in all states; the block never writes.

Decomposition:
- Shared package ram_pkg holds:
  - FSM state enum (IDLE/READ/DRAIN/DONE);
  - ADDR_W/DATA_W/DEPTH defaults, shared with the write generator;
  - expected-value function expected(seed, addr), so writer and checker use one pattern definition.
- One natural sub-module: ram_rd_pipe, the parameterised READ_LAT-deep valid/addr delay line.

Test Plan:
- RAM model preloaded with expected values, READ_LAT=1, start pulse -> addra 0..31 with ena=1 for 32 cycles, done at t0+34, pass=1, err_cnt=0.
- Words 5 (0xAA) and 17 (0x00) corrupted -> err_cnt=2, first_err_addr=5, first_err_data=0xAA, pass=0.
- READ_LAT=2 with an output-registered RAM model, SEED=250 -> no mismatches (checks wrap of expected), done at t0+35.
- start re-pulsed at addra=12 -> sweep continues unchanged, single done pulse; start in the DONE cycle -> new sweep begins next cycle with err_cnt cleared.
- rst low when addra=10 -> all outputs 0 at once, ena=0; after release, a new start yields a full, correct 32-word sweep.
